// File: rtl/systolic_pkg.sv
// Shared definitions for the weight-stationary array sequencer:
// job phases and the fixed pipeline offsets the edge timing depends on.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    SWITCH,
    STREAM,
    DRAIN
  } state_e;

  // Buffer RAM read latency, and cycles from a row's switch to its first valid.
  localparam int unsigned RAM_LAT         = 1;
  localparam int unsigned SWITCH_TO_VALID = 1;

endpackage

// File: rtl/skew_line.sv
// One-bit delay line with synchronous reset; DEPTH=0 is a plain wire.
// Used to stagger per-row edge control across the array rows.
module skew_line #(
  parameter int DEPTH = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  if (DEPTH == 0) begin : g_wire
    // Row 0 needs no delay; clock and reset are deliberately left unused here.
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;
    assign q_o = d_i;
  end else begin : g_shift
    logic [DEPTH-1:0] sr_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        sr_q <= '0;
      end else begin
        sr_q <= DEPTH'({sr_q, d_i});
      end
    end

    assign q_o = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequences one weight-stationary job: weight preload, switch, skewed
// activation streaming and drain, with a start/busy/done host handshake.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int N      = 4,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_vecs,
  output logic              busy,
  output logic              done,
  output logic              w_rd_en,
  output logic [ADDR_W-1:0] w_rd_addr,
  output logic              in_rd_en,
  output logic [ADDR_W-1:0] in_rd_addr,
  output logic              accept_w,
  output logic [N-1:0]      switch_row,
  output logic [N-1:0]      valid_row,
  output logic              pe_en
);

  // Two extra bits so the last job cycle 3N+M always fits.
  localparam int CW = CNT_W + 2;
  localparam logic [CW-1:0] N_C     = CW'(N);
  localparam logic [CW-1:0] THREE_N = CW'(3 * N);
  localparam logic [CW-1:0] ACC_LO  = CW'(RAM_LAT);
  localparam logic [CW-1:0] ACC_HI  = CW'(N + RAM_LAT);
  localparam logic [CW-1:0] SW_CYC  = N_C + CW'(1);
  localparam logic [CW-1:0] VAL_LO  = SW_CYC + CW'(SWITCH_TO_VALID);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]  m_q, m_d;
  logic [CW-1:0]     m_ext;
  logic [CW-1:0]     job_last;
  logic              active;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              w_rd_en_q, w_rd_en_d;
  logic [ADDR_W-1:0] w_rd_addr_q, w_rd_addr_d;
  logic              in_rd_en_q, in_rd_en_d;
  logic [ADDR_W-1:0] in_rd_addr_q, in_rd_addr_d;
  logic              accept_w_q, accept_w_d;
  logic              sw_head_q, sw_head_d;
  logic              val_head_q, val_head_d;

  assign job_last = THREE_N + CW'(m_q);

  // Every output is computed for the cycle about to start, then registered.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    m_d          = m_q;
    active       = 1'b0;
    m_ext        = '0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    w_rd_en_d    = 1'b0;
    w_rd_addr_d  = '0;
    in_rd_en_d   = 1'b0;
    in_rd_addr_d = '0;
    accept_w_d   = 1'b0;
    sw_head_d    = 1'b0;
    val_head_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && (num_vecs != '0)) begin
          m_d    = num_vecs;
          cnt_d  = '0;
          active = 1'b1;
        end
      end
      default: begin
        if (cnt_q != job_last) begin
          cnt_d  = cnt_q + CW'(1);
          active = 1'b1;
        end
      end
    endcase

    m_ext = CW'(m_d);

    if (!active)                   state_d = IDLE;
    else if (cnt_d < N_C)          state_d = LOAD_W;
    else if (cnt_d == N_C)         state_d = SWITCH;
    else if (cnt_d <= N_C + m_ext) state_d = STREAM;
    else                           state_d = DRAIN;

    busy_d     = active;
    w_rd_en_d  = (state_d == LOAD_W);
    in_rd_en_d = (state_d == STREAM);
    if (w_rd_en_d)  w_rd_addr_d  = ADDR_W'(N_C - CW'(1) - cnt_d);
    if (in_rd_en_d) in_rd_addr_d = ADDR_W'(cnt_d - SW_CYC);
    // Weight data arrives one RAM latency after the read, spanning LOAD_W into SWITCH.
    accept_w_d = active && (cnt_d >= ACC_LO) && (cnt_d < ACC_HI);
    sw_head_d  = in_rd_en_d && (cnt_d == SW_CYC);
    val_head_d = active && (cnt_d >= VAL_LO) && (cnt_d < VAL_LO + m_ext);
    done_d     = (state_d == DRAIN) && (cnt_d == THREE_N + m_ext);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      m_q          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      w_rd_en_q    <= 1'b0;
      w_rd_addr_q  <= '0;
      in_rd_en_q   <= 1'b0;
      in_rd_addr_q <= '0;
      accept_w_q   <= 1'b0;
      sw_head_q    <= 1'b0;
      val_head_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      m_q          <= m_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      w_rd_en_q    <= w_rd_en_d;
      w_rd_addr_q  <= w_rd_addr_d;
      in_rd_en_q   <= in_rd_en_d;
      in_rd_addr_q <= in_rd_addr_d;
      accept_w_q   <= accept_w_d;
      sw_head_q    <= sw_head_d;
      val_head_q   <= val_head_d;
    end
  end

  // Row r sees the row-0 switch and valid pulses delayed by r cycles.
  for (genvar r = 0; r < N; r++) begin : g_row
    skew_line #(.DEPTH(r)) u_switch_skew (
      .clk_i (clk),
      .rst_i (rst),
      .d_i   (sw_head_q),
      .q_o   (switch_row[r])
    );
    skew_line #(.DEPTH(r)) u_valid_skew (
      .clk_i (clk),
      .rst_i (rst),
      .d_i   (val_head_q),
      .q_o   (valid_row[r])
    );
  end

  assign busy       = busy_q;
  assign pe_en      = busy_q;
  assign done       = done_q;
  assign w_rd_en    = w_rd_en_q;
  assign w_rd_addr  = w_rd_addr_q;
  assign in_rd_en   = in_rd_en_q;
  assign in_rd_addr = in_rd_addr_q;
  assign accept_w   = accept_w_q;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: job-timeline model compared every
// cycle, plus hand-computed expectations for an N=4, M=3 job.
module tb_systolic_ctrl;

  localparam int N      = 4;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 16;
  localparam int OW     = 3 + 1 + ADDR_W + 1 + ADDR_W + 1 + 2 * N;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CNT_W-1:0]  numVecs;
  logic              busy, done, wRdEn, inRdEn, acceptW, peEn;
  logic [ADDR_W-1:0] wRdAddr, inRdAddr;
  logic [N-1:0]      switchRow, validRow;

  always #5 clk = ~clk;

  systolic_ctrl #(.N(N), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_vecs   (numVecs),
    .busy       (busy),
    .done       (done),
    .w_rd_en    (wRdEn),
    .w_rd_addr  (wRdAddr),
    .in_rd_en   (inRdEn),
    .in_rd_addr (inRdAddr),
    .accept_w   (acceptW),
    .switch_row (switchRow),
    .valid_row  (validRow),
    .pe_en      (peEn)
  );

  int checks    = 0;
  int errors    = 0;
  int doneCount = 0;
  bit checking  = 1'b0;

  // Job timeline as seen by the host: active flag, cycle index within job, M.
  bit mActive = 1'b0;
  int mK      = 0;
  int mM      = 0;

  logic [OW-1:0] dutOut;
  logic [OW-1:0] expOut;
  assign dutOut = {busy, peEn, done, wRdEn, wRdAddr, inRdEn, inRdAddr, acceptW, switchRow, validRow};

  // Hand-computed edge activity for N=4, M=3, indexed by job cycle 0..16.
  bit         litBusy[17]   = '{1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0};
  bit         litDone[17]   = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,0};
  bit         litWen[17]    = '{1,1,1,1,0,0,0,0,0,0,0,0,0,0,0,0,0};
  int         litWaddr[17]  = '{3,2,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
  bit         litAcc[17]    = '{0,1,1,1,1,0,0,0,0,0,0,0,0,0,0,0,0};
  bit         litInEn[17]   = '{0,0,0,0,0,1,1,1,0,0,0,0,0,0,0,0,0};
  int         litInAddr[17] = '{0,0,0,0,0,0,1,2,0,0,0,0,0,0,0,0,0};
  logic [3:0] litSw[17]     = '{4'h0,4'h0,4'h0,4'h0,4'h0,4'h1,4'h2,4'h4,4'h8,
                                4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0};
  logic [3:0] litVal[17]    = '{4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h1,4'h3,4'h7,
                                4'hE,4'hC,4'h8,4'h0,4'h0,4'h0,4'h0,4'h0};

  function automatic logic [OW-1:0] modelOut(bit act, int k, int m);
    logic              bsy, dn, wen, ien, acc;
    logic [ADDR_W-1:0] wa, ia;
    logic [N-1:0]      sw, vl;
    bsy = act;
    dn  = act && (k == 3 * N + m);
    wen = act && (k < N);
    wa  = wen ? ADDR_W'(N - 1 - k) : '0;
    acc = act && (k >= 1) && (k <= N);
    ien = act && (k >= N + 1) && (k <= N + m);
    ia  = ien ? ADDR_W'(k - N - 1) : '0;
    for (int r = 0; r < N; r++) begin
      sw[r] = act && (k == N + 1 + r);
      vl[r] = act && (k >= N + 2 + r) && (k <= N + 1 + m + r);
    end
    return {bsy, bsy, dn, wen, wa, ien, ia, acc, sw, vl};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mActive <= 1'b0;
    end else if (mActive) begin
      if (mK == 3 * N + mM) mActive <= 1'b0;
      else                  mK      <= mK + 1;
    end else if (start && (numVecs != '0)) begin
      mActive <= 1'b1;
      mK      <= 0;
      mM      <= int'(numVecs);
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      expOut = modelOut(mActive, mK, mM);
      checks++;
      if (dutOut !== expOut) begin
        errors++;
        $display("[TB] FAIL cycleCompare t=%0t k=%0d actual=%h expected=%h", $time, mK, dutOut, expOut);
      end
      if (done === 1'b1) doneCount++;
    end
  end

  task automatic applyStimulus(input bit s, input int nv, input bit r);
    start   = s;
    numVecs = CNT_W'(nv);
    rst     = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic runDirectedJob();
    logic [63:0] lit;
    applyStimulus(1'b1, 3, 1'b0);
    for (int k = 0; k < 17; k++) begin
      lit = 64'({litBusy[k], litDone[k], litWen[k], ADDR_W'(litWaddr[k]), litAcc[k],
                 litInEn[k], ADDR_W'(litInAddr[k]), litSw[k], litVal[k]});
      checkOutput($sformatf("directed_k%0d", k),
                  64'({busy, done, wRdEn, wRdAddr, acceptW, inRdEn, inRdAddr, switchRow, validRow}), lit);
      if (k < 16) applyStimulus(1'b0, 9, 1'b0);
    end
  endtask

  initial begin
    int d0, m, abortAt;
    rst     = 1'b1;
    start   = 1'b0;
    numVecs = '0;
    repeat (2) @(posedge clk);
    #1;
    checking = 1'b1;
    checkOutput("resetState", 64'(dutOut), 64'd0);
    applyStimulus(1'b0, 0, 1'b1);
    applyStimulus(1'b0, 0, 1'b0);

    runDirectedJob();

    // A zero-length request must be ignored entirely.
    d0 = doneCount;
    applyStimulus(1'b1, 0, 1'b0);
    applyStimulus(1'b1, 0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("zeroVecIdle", 64'(dutOut), 64'd0);
    checkOutput("zeroVecNoDone", 64'(doneCount - d0), 64'd0);

    // Starts at cycles 3, 10 and the done cycle of an M=4 job are ignored.
    d0 = doneCount;
    applyStimulus(1'b1, 4, 1'b0);
    for (int k = 0; k <= 16; k++) applyStimulus((k == 3) || (k == 10) || (k == 16), 7, 1'b0);
    checkOutput("midStartBusyLow", 64'(busy), 64'd0);
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("doneCycleStartIgnored", 64'(busy), 64'd0);
    checkOutput("midStartOneDone", 64'(doneCount - d0), 64'd1);

    // Reset during cycle 7 of an M=5 job aborts it without a done pulse.
    d0 = doneCount;
    applyStimulus(1'b1, 5, 1'b0);
    for (int k = 0; k < 7; k++) applyStimulus(1'b0, 0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1);
    checkOutput("abortAllZero", 64'(dutOut), 64'd0);
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("abortStaysIdle", 64'(busy), 64'd0);
    checkOutput("abortNoDone", 64'(doneCount - d0), 64'd0);
    runDirectedJob();

    for (int j = 0; j < 25; j++) begin
      repeat ($urandom_range(0, 3)) applyStimulus(1'b0, int'($urandom_range(0, 15)), 1'b0);
      if (j == 5)                          m = 260;
      else if ($urandom_range(0, 7) == 0)  m = 0;
      else                                 m = int'($urandom_range(1, 12));
      applyStimulus(1'b1, m, 1'b0);
      abortAt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3 * N + m)) : -1;
      for (int k = 0; k <= 3 * N + m; k++)
        applyStimulus($urandom_range(0, 5) == 0, int'($urandom_range(0, 12)), k == abortAt);
    end
    repeat (300) applyStimulus(1'b0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
